// File: rtl/median_pkg.sv
// Shared types for the 3x3 median window sequencer: FSM states, sorter tag and pixel type.
package median_pkg;

    typedef logic [7:0] pix_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROW0  = 3'd1,
        RUN   = 3'd2,
        EOL   = 3'd3,
        FLUSH = 3'd4,
        DRAIN = 3'd5
    } state_t;

    typedef struct packed {
        logic valid;
        logic border;
        pix_t centre_px;
        logic sof;
        logic eol;
    } tag_t;

    localparam int SORT_LAT_DEFAULT = 10;

endpackage

// File: rtl/median_line_buffer.sv
// One row of pixel storage with registered read; 'newest' tracks whether this bank holds the latest row.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter bit INIT_NEWEST = 1'b0,
    parameter int AW          = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pix_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output pix_t          rd_data,
    input  logic          rotate,
    output logic          newest
);

    pix_t mem_r [IMG_W];
    pix_t rd_data_r;
    logic newest_r;

    // Row storage write port (contents are don't-care after reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; same-address write in this cycle yields the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    // Bank role flips at every row boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            newest_r <= INIT_NEWEST;
        end else if (rotate) begin
            newest_r <= ~newest_r;
        end
    end

    assign rd_data = rd_data_r;
    assign newest  = newest_r;

endmodule

// File: rtl/median_window_ctrl.sv
// Raster-scan frame sequencer: buffers two rows, issues 3x3 windows to an external
// pipelined median sorter and re-aligns results with a tag pipeline.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int SORT_LAT = SORT_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pix_in_valid,
    output logic       pix_in_ready,
    input  logic [7:0] pix_in,
    output logic       sort_enable,
    output logic [7:0] sort_px0,
    output logic [7:0] sort_px1,
    output logic [7:0] sort_px2,
    output logic [7:0] sort_px3,
    output logic [7:0] sort_px4,
    output logic [7:0] sort_px5,
    output logic [7:0] sort_px6,
    output logic [7:0] sort_px7,
    output logic [7:0] sort_px8,
    input  logic [7:0] sort_median,
    output logic       pix_out_valid,
    output logic [7:0] pix_out,
    output logic       pix_out_sof,
    output logic       pix_out_eol,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);

    state_t        state_r, state_s;
    logic [RW-1:0] in_row_r, out_row_r;
    logic [CW-1:0] in_col_r, out_col_r, rd_addr_s;
    pix_t          col_a_r [3];
    pix_t          col_b_r [3];
    tag_t          tag_pipe_r [SORT_LAT];
    tag_t          tag_in_s, tail_s;
    pix_t          pix_hold_r, pix_out_s, centre_s, rd_a_s, rd_b_s, rd_old_s, rd_new_s;
    logic          ready_s, accept_s, row_end_s, issue_s, busy_s, drain_last_s;
    logic          newest_a_s, newest_b_s, frame_done_r;

    median_line_buffer #(.IMG_W(IMG_W), .INIT_NEWEST(1'b1)) u_lb_a (
        .clk(clk), .rst(rst), .wr_en(accept_s && !newest_a_s), .wr_addr(in_col_r),
        .wr_data(pix_in), .rd_addr(rd_addr_s), .rd_data(rd_a_s), .rotate(row_end_s),
        .newest(newest_a_s)
    );

    median_line_buffer #(.IMG_W(IMG_W), .INIT_NEWEST(1'b0)) u_lb_b (
        .clk(clk), .rst(rst), .wr_en(accept_s && !newest_b_s), .wr_addr(in_col_r),
        .wr_data(pix_in), .rd_addr(rd_addr_s), .rd_data(rd_b_s), .rotate(row_end_s),
        .newest(newest_b_s)
    );

    assign rd_new_s = newest_a_s ? rd_a_s : rd_b_s;
    assign rd_old_s = newest_a_s ? rd_b_s : rd_a_s;

    // Next state, issue decision and read prefetch address (next column once accepted)
    always_comb begin
        state_s   = state_r;
        ready_s   = (state_r == ROW0) || (state_r == RUN);
        accept_s  = pix_in_valid && ready_s;
        row_end_s = accept_s && (in_col_r == COL_LAST);
        issue_s   = 1'b0;
        centre_s  = col_b_r[1];
        busy_s    = 1'b0;
        if (accept_s) begin
            rd_addr_s = (in_col_r == COL_LAST) ? COL_ZERO : in_col_r + 1'b1;
        end else begin
            rd_addr_s = in_col_r;
        end
        for (int i = 0; i < SORT_LAT - 1; i++) begin
            busy_s = busy_s | tag_pipe_r[i].valid;
        end
        drain_last_s = tag_pipe_r[SORT_LAT-1].valid && !busy_s;
        case (state_r)
            IDLE: begin
                if (frame_start) state_s = ROW0;
                else             state_s = IDLE;
            end
            ROW0: begin
                if (row_end_s) state_s = RUN;
                else           state_s = ROW0;
            end
            RUN: begin
                issue_s = accept_s && (in_col_r != COL_ZERO);
                if (row_end_s) state_s = EOL;
                else           state_s = RUN;
            end
            EOL: begin
                issue_s = 1'b1;
                if (out_row_r == ROW_PEN) state_s = FLUSH;
                else                      state_s = RUN;
            end
            FLUSH: begin
                // Bottom row is all border: only the centre from the newest bank matters
                issue_s   = 1'b1;
                centre_s  = rd_new_s;
                rd_addr_s = (out_col_r == COL_LAST) ? COL_ZERO : out_col_r + 1'b1;
                if (out_col_r == COL_LAST) state_s = DRAIN;
                else                       state_s = FLUSH;
            end
            DRAIN: begin
                if (drain_last_s) state_s = IDLE;
                else              state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Tag describing the centre being issued this cycle
    always_comb begin
        tag_in_s = '0;
        if (issue_s) begin
            tag_in_s.valid     = 1'b1;
            tag_in_s.border    = (out_row_r == ROW_ZERO) || (out_row_r == ROW_LAST) ||
                                 (out_col_r == COL_ZERO) || (out_col_r == COL_LAST);
            tag_in_s.centre_px = centre_s;
            tag_in_s.sof       = (out_row_r == ROW_ZERO) && (out_col_r == COL_ZERO);
            tag_in_s.eol       = (out_col_r == COL_LAST);
        end else begin
            tag_in_s = '0;
        end
    end

    // State register plus input and issue position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_row_r  <= ROW_ZERO;
            in_col_r  <= COL_ZERO;
            out_row_r <= ROW_ZERO;
            out_col_r <= COL_ZERO;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && frame_start) begin
                in_row_r  <= ROW_ZERO;
                in_col_r  <= COL_ZERO;
                out_row_r <= ROW_ZERO;
                out_col_r <= COL_ZERO;
            end
            if (accept_s) begin
                in_col_r <= (in_col_r == COL_LAST) ? COL_ZERO : in_col_r + 1'b1;
                if (in_col_r == COL_LAST) begin
                    in_row_r <= (in_row_r == ROW_LAST) ? ROW_ZERO : in_row_r + 1'b1;
                end
            end
            if (issue_s) begin
                out_col_r <= (out_col_r == COL_LAST) ? COL_ZERO : out_col_r + 1'b1;
                if (out_col_r == COL_LAST) begin
                    out_row_r <= (out_row_r == ROW_LAST) ? ROW_ZERO : out_row_r + 1'b1;
                end
            end
        end
    end

    // Column window registers: col_a = c-2, col_b = c-1; column c is live from buffers/pix_in
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                col_a_r[i] <= 8'd0;
                col_b_r[i] <= 8'd0;
            end
        end else if (accept_s) begin
            col_a_r    <= col_b_r;
            col_b_r[0] <= rd_old_s;
            col_b_r[1] <= rd_new_s;
            col_b_r[2] <= pix_in;
        end
    end

    // Tag pipeline runs every cycle, matching the free-running sorter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SORT_LAT; i++) tag_pipe_r[i] <= '0;
        end else begin
            tag_pipe_r[0] <= tag_in_s;
            for (int i = 1; i < SORT_LAT; i++) tag_pipe_r[i] <= tag_pipe_r[i-1];
        end
    end

    // Output select at the tail of the tag pipeline; holds last value between pixels
    always_comb begin
        tail_s = tag_pipe_r[SORT_LAT-1];
        if (tail_s.valid) begin
            pix_out_s = tail_s.border ? tail_s.centre_px : sort_median;
        end else begin
            pix_out_s = pix_hold_r;
        end
    end

    // Held pixel value and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_hold_r   <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            pix_hold_r   <= pix_out_s;
            frame_done_r <= (state_r == DRAIN) && drain_last_s;
        end
    end

    assign pix_in_ready  = ready_s;
    assign sort_enable   = (state_r != IDLE);
    assign sort_px0      = col_a_r[0];
    assign sort_px1      = col_b_r[0];
    assign sort_px2      = rd_old_s;
    assign sort_px3      = col_a_r[1];
    assign sort_px4      = col_b_r[1];
    assign sort_px5      = rd_new_s;
    assign sort_px6      = col_a_r[2];
    assign sort_px7      = col_b_r[2];
    assign sort_px8      = pix_in;
    assign pix_out_valid = tail_s.valid;
    assign pix_out       = pix_out_s;
    assign pix_out_sof   = tail_s.valid && tail_s.sof;
    assign pix_out_eol   = tail_s.valid && tail_s.eol;
    assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl with a behavioural 10-stage median sorter.
module tb_median_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int LAT = 10;
    localparam int N = W * H;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, frame_start, pix_in_valid, pix_in_ready, sort_enable;
    logic [7:0] pix_in, sort_median, pix_out;
    logic [7:0] sort_px0, sort_px1, sort_px2, sort_px3, sort_px4, sort_px5, sort_px6, sort_px7, sort_px8;
    logic       pix_out_valid, pix_out_sof, pix_out_eol, frame_done;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   done_cnt = 0;
    int   ready_hi_cnt = 0;
    int   last_valid_cyc = 0;
    logic [7:0] last_pix = 8'd0;
    int   acc_cyc_q[$];
    int   valid_cyc_q[$];
    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] img [N];
    logic [7:0] win [9];
    logic [7:0] sort_stage [LAT];

    median_window_ctrl #(.IMG_W(W), .IMG_H(H), .SORT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_in_valid(pix_in_valid),
        .pix_in_ready(pix_in_ready), .pix_in(pix_in), .sort_enable(sort_enable),
        .sort_px0(sort_px0), .sort_px1(sort_px1), .sort_px2(sort_px2), .sort_px3(sort_px3),
        .sort_px4(sort_px4), .sort_px5(sort_px5), .sort_px6(sort_px6), .sort_px7(sort_px7),
        .sort_px8(sort_px8), .sort_median(sort_median), .pix_out_valid(pix_out_valid),
        .pix_out(pix_out), .pix_out_sof(pix_out_sof), .pix_out_eol(pix_out_eol),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j] < a[j-1]) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        return a[4];
    endfunction

    // Behavioural sorter: window present in cycle t gives its median in cycle t+LAT
    assign win[0] = sort_px0; assign win[1] = sort_px1; assign win[2] = sort_px2;
    assign win[3] = sort_px3; assign win[4] = sort_px4; assign win[5] = sort_px5;
    assign win[6] = sort_px6; assign win[7] = sort_px7; assign win[8] = sort_px8;
    always @(posedge clk) begin
        if (sort_enable) begin
            sort_stage[0] <= med9(win);
            for (int k = 1; k < LAT; k++) sort_stage[k] <= sort_stage[k-1];
        end
    end
    assign sort_median = sort_stage[LAT-1];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [7:0] v [9];
        int k;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    e.pix = img[r*W+c];
                end else begin
                    k = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            v[k] = img[(r+dr)*W + (c+dc)];
                            k++;
                        end
                    end
                    e.pix = med9(v);
                end
                e.sof = (r == 0 && c == 0);
                e.eol = (c == W - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    // Output monitor: scoreboard compare, hold check, frame_done timing
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                last_pix = 8'd0;
            end else begin
                if (pix_in_valid && pix_in_ready) acc_cyc_q.push_back(cyc);
                if (pix_in_ready) ready_hi_cnt++;
                if (pix_out_valid) begin
                    out_cnt++;
                    valid_cyc_q.push_back(cyc);
                    last_valid_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_out", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check_eq("pix", int'(pix_out), int'(mon_e.pix));
                        check_eq("sof", int'(pix_out_sof), int'(mon_e.sof));
                        check_eq("eol", int'(pix_out_eol), int'(mon_e.eol));
                    end
                    last_pix = pix_out;
                end else begin
                    check_eq("hold", int'(pix_out), int'(last_pix));
                end
                if (frame_done) begin
                    done_cnt++;
                    check_eq("done_timing", cyc - last_valid_cyc, 1);
                end
            end
        end
    end

    task automatic run_frame(input bit bubbles, input bit fs_mid, input int abort_at);
        int base_done, base_out, t;
        bit aborted;
        aborted = 1'b0;
        base_done = done_cnt;
        base_out = out_cnt;
        if (abort_at < 0) push_expected();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < N && !aborted; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                pix_in_valid = 1'b0;
                aborted = 1'b1;
            end else begin
                if (bubbles && i > 0) begin
                    pix_in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                pix_in_valid = 1'b1;
                pix_in = img[i];
                frame_start = fs_mid && (i == 6);
                t = 0;
                @(negedge clk);
                while (!pix_in_ready && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 50) check_eq("ready_timeout", 0, 1);
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        end
        pix_in_valid = 1'b0;
        if (aborted) begin
            repeat (40) @(negedge clk);
            check_eq("abort_no_out", out_cnt - base_out, 0);
            check_eq("abort_no_done", done_cnt - base_done, 0);
        end else begin
            t = 0;
            while (done_cnt == base_done && t < 200) begin
                @(negedge clk);
                t++;
            end
            repeat (5) @(negedge clk);
            check_eq("done_once", done_cnt - base_done, 1);
            check_eq("out_count", out_cnt - base_out, N);
            check_eq("sb_empty", sb_q.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_val, base_rdy;
        rst = 1'b1;
        frame_start = 1'b0;
        pix_in_valid = 1'b0;
        pix_in = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", int'(pix_out_valid), 0);
        check_eq("rst_ready", int'(pix_in_ready), 0);
        check_eq("rst_sort_en", int'(sort_enable), 0);
        check_eq("rst_done", int'(frame_done), 0);
        check_eq("rst_pix", int'(pix_out), 0);
        check_eq("rst_sof", int'(pix_out_sof), 0);
        check_eq("rst_eol", int'(pix_out_eol), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Constant frame with timing checks
        for (int i = 0; i < N; i++) img[i] = 8'd100;
        base_acc = acc_cyc_q.size();
        base_val = valid_cyc_q.size();
        base_rdy = ready_hi_cnt;
        run_frame(1'b0, 1'b0, -1);
        check_eq("first_latency", valid_cyc_q[base_val] - acc_cyc_q[base_acc+5], 10);
        check_eq("eol_gap", acc_cyc_q[base_acc+8] - acc_cyc_q[base_acc+7] - 1, 1);
        check_eq("ready_cycles", ready_hi_cnt - base_rdy, N);

        // Interior impulse is removed
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[1*W+1] = 8'd255;
        run_frame(1'b0, 1'b0, -1);

        // Corner impulse passes through as a border pixel
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[0] = 8'd255;
        run_frame(1'b0, 1'b0, -1);

        // Ramp without and with input bubbles
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) img[r*W+c] = 8'(16*r + c);
        end
        run_frame(1'b0, 1'b0, -1);
        run_frame(1'b1, 1'b0, -1);

        // Abort mid-frame, then a full random frame
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, 1'b0, 6);
        run_frame(1'b0, 1'b0, -1);

        // frame_start during RUN must be ignored
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, 1'b1, -1);
        repeat (20) @(negedge clk);
        check_eq("final_out_total", out_cnt, 7 * N);
        check_eq("final_done_total", done_cnt, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/median_window_ctrl.md
Name: median_window_ctrl

Overview:
- Frame-level sequencer for the 9-pixel pipelined median sorter.
- Accepts a raster-scan 8-bit grayscale stream and stores the two previous rows in internal line buffers.
- Issues one 3x3 window per cycle to the sorter and tracks the sorter latency with a tag pipeline.
- Emits exactly one filtered pixel per input pixel, in raster order. Border pixels pass through unchanged.

Parameters:
IMG_W, 640, pixels per row (>=3)
IMG_H, 480, rows per frame (>=3)
SORT_LAT, 10, clock edges from window issue to valid sorter median output

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse; arms a new frame (honoured only in IDLE)
pix_in_valid  in  1  input pixel valid
pix_in_ready  out  1  input pixel accepted when valid && ready
pix_in  in  8  input pixel, raster order
sort_enable  out  1  sorter enable
sort_px0..sort_px8  out  8 each  window to sorter; row-major, px0=(r-1,c-1), px4=centre (r,c), px8=(r+1,c+1)
sort_median  in  8  sorter median output
pix_out_valid  out  1  filtered pixel valid (no backpressure)
pix_out  out  8  filtered pixel
pix_out_sof  out  1  marks output pixel (0,0)
pix_out_eol  out  1  marks output pixel (r,IMG_W-1)
frame_done  out  1  one-cycle pulse after the last output pixel of the frame

Behaviour:
- Reset (sync, active-high) clears the FSM to IDLE, the counters, and the tag pipeline. In-flight tags are dropped.
- Output values at reset: all outputs 0, except the sort_px* windows, which are don't-care.
- Reset asserted mid-frame aborts the frame. No pix_out_valid or frame_done is produced for the aborted frame.
- Counters: in_row and in_col track the input position; out_row and out_col track the issue centre. Column counters wrap IMG_W-1 -> 0 and increment the row.
- FSM states:
  - IDLE: pix_in_ready=0, sort_enable=0. frame_start -> ROW0.
  - ROW0: ready=1; accept row 0 into the line buffer; no issue. After the last pixel of row 0 -> RUN.
  - RUN: ready=1.
    - Accepting (r+1,0) issues nothing.
    - Accepting (r+1,c), c>=1, issues centre (r,c-1).
    - After accepting (r+1,IMG_W-1) -> EOL.
  - EOL: ready=0 for exactly one cycle; issues centre (r,IMG_W-1). Then -> RUN, or -> FLUSH if r+1==IMG_H-1.
  - FLUSH: ready=0 for IMG_W cycles; issues centres (IMG_H-1, 0..IMG_W-1) from the line buffer. Then -> DRAIN.
  - DRAIN: ready=0; wait until the tag pipeline is empty. Pulse frame_done on the cycle after the last pix_out_valid. -> IDLE.
- frame_start outside IDLE is ignored.
- sort_enable is 1 in every state except IDLE and is never dropped mid-frame.
- Window assembly: column registers hold three columns from rows r-1, r, r+1. Positions outside the frame are don't-care, because those centres are border pixels.
- Tag pipeline: SORT_LAT deep. Each issue pushes {valid, border, centre_px, sof, eol}.
  - border = (row==0 || row==IMG_H-1 || col==0 || col==IMG_W-1).
  - At the tail: pix_out_valid=tag.valid; pix_out = border ? centre_px : sort_median.
- Latency: pix_out_valid occurs exactly SORT_LAT cycles after the issue cycle.
- Output count is exactly IMG_W*IMG_H per frame.
- Between output pixels, pix_out holds its last value.
- Stalls: pix_in_valid low while in ROW0 or RUN issues nothing that cycle. The sorter keeps running; its output is unused because the tags stay invalid.
- Line buffers: two IMG_W x 8 single-port-read/single-write arrays, rotated at each row boundary. Read and write to the same address in the same cycle returns the old data.

Decomposition:
- Package median_pkg holds:
  - the state enum typedef (IDLE, ROW0, RUN, EOL, FLUSH, DRAIN);
  - the tag struct typedef;
  - the pixel type (logic [7:0]);
  - the localparam for the default SORT_LAT (10).
- One sub-module, median_line_buffer: a parameterised IMG_W-deep, 8-bit, synchronous-read row store with a rotate input. Instantiated twice.
- The sorter itself sits outside this block and connects through the sort_* ports.

Test Plan (IMG_W=4, IMG_H=3, SORT_LAT=10, sorter model attached):
- Constant frame, all 100, pix_in_valid held high -> 12 outputs of 100.
  - pix_out_sof on output 0; pix_out_eol on outputs 3, 7, 11.
  - frame_done one cycle after output 11.
- Impulse: 255 at (1,1), 0 elsewhere -> output (1,1)=0, (1,2)=0, all others 0. Repeat with 255 at (0,0) -> output (0,0)=255 (border pass-through).
- Timing, with valid held high:
  - First issue on acceptance of (1,1); first pix_out_valid exactly 10 cycles later.
  - pix_in_ready low for exactly 1 cycle after (1,3), then low from after (2,3) onward (EOL then FLUSH for 4 cycles).
- Input bubbles: deassert pix_in_valid every other cycle with a ramp input (value = 16*row + col) -> output order and values are identical to the no-bubble run, and each interior output equals the median of its 3x3 ramp neighbourhood.
- Reset mid-frame: assert rst while in RUN, then release -> no pix_out_valid and no frame_done appear. A new frame_start then produces a correct, complete 12-pixel frame.
- frame_start pulsed during RUN -> ignored. The frame completes normally with exactly 12 outputs and one frame_done.
